// File: rtl/obstaculos_map_loader_if.sv
// Byte-stream and obstacle-write bundle for obstaculos_map_loader.
// master: byte source / memory-manager side. slave: the loader itself.
interface obstaculos_map_loader_if #(
    parameter int unsigned ADDR_WIDTH = 8
);
    logic                  byte_valid_in;
    logic [7:0]            byte_data_in;
    logic                  byte_ready_out;
    logic                  obstaculos_wr_enable_out;
    logic [ADDR_WIDTH-1:0] obstaculos_wr_addr_out;
    logic                  obstaculos_wr_data_out;

    modport master (
        output byte_valid_in,
        output byte_data_in,
        input  byte_ready_out,
        input  obstaculos_wr_enable_out,
        input  obstaculos_wr_addr_out,
        input  obstaculos_wr_data_out
    );

    modport slave (
        input  byte_valid_in,
        input  byte_data_in,
        output byte_ready_out,
        output obstaculos_wr_enable_out,
        output obstaculos_wr_addr_out,
        output obstaculos_wr_data_out
    );
endinterface

// File: rtl/obstaculos_map_loader.sv
// Obstacle map loader: serialises a byte stream (8 cells per byte, LSB = lowest address) into
// 1-bit writes on the obstacle memory port, or bulk-clears every cell to 0.
// Optional macro OBSTACULOS_MAP_COUNT_EN adds obst_count_out, the number of 1-cells written by
// the current/last operation.
module obstaculos_map_loader #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned MAP_CELLS  = 2 ** ADDR_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_clear_in,
    input  logic                    start_load_in,
    input  logic                    abort_in,
    obstaculos_map_loader_if.slave  bus,
    output logic                    busy_out,
    output logic                    done_out,
    output logic                    error_out
`ifdef OBSTACULOS_MAP_COUNT_EN
    ,
    output logic [ADDR_WIDTH:0]     obst_count_out
`endif
);

    localparam int unsigned CntW = ADDR_WIDTH + 1;
    localparam logic [CntW-1:0] LastAddr = CntW'(MAP_CELLS - 1);

    typedef enum logic [2:0] {StIdle, StClear, StWaitByte, StShift, StDone} state_e;

    state_e                state_q, state_d;
    logic [CntW-1:0]       addr_q, addr_d;    // address of the write being presented / next
    logic [2:0]            bit_q, bit_d;
    logic [7:0]            shift_q, shift_d;  // bit 0 is the cell being written
    logic                  ready_q, ready_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic                  wr_data_q, wr_data_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic                  busy_now;
    logic                  at_last;
    logic                  starting;

    // Next-state logic; every output is derived from the next state so it lands registered.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        done_d   = done_q;
        busy_now = (state_q == StClear) || (state_q == StWaitByte) || (state_q == StShift);
        at_last  = (addr_q == LastAddr);
        starting = 1'b0;
        error_d  = busy_now && (start_clear_in || start_load_in);

        unique case (state_q)
            StIdle, StDone: begin
                // Clear wins when both starts arrive together; abort has no effect here.
                if (start_clear_in) begin
                    state_d  = StClear;
                    addr_d   = '0;
                    done_d   = 1'b0;
                    starting = 1'b1;
                end else if (start_load_in) begin
                    state_d  = StWaitByte;
                    addr_d   = '0;
                    done_d   = 1'b0;
                    starting = 1'b1;
                end
            end
            StClear: begin
                if (abort_in) begin
                    state_d = StIdle;
                end else if (at_last) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            StWaitByte: begin
                if (abort_in) begin
                    state_d = StIdle;
                end else if (bus.byte_valid_in && ready_q) begin
                    shift_d = bus.byte_data_in;
                    bit_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                if (abort_in) begin
                    state_d = StIdle;
                end else if (at_last) begin
                    // Map full: remaining bits of this byte are dropped.
                    state_d = StDone;
                    done_d  = 1'b1;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) begin
                        state_d = StWaitByte;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d    = (state_d == StClear) || (state_d == StWaitByte) || (state_d == StShift);
        ready_d   = (state_d == StWaitByte);
        wr_en_d   = (state_d == StClear) || (state_d == StShift);
        wr_addr_d = addr_d[ADDR_WIDTH-1:0];
        wr_data_d = (state_d == StShift) && shift_d[0];
    end

    // State and registered outputs, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            ready_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            ready_q   <= ready_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

    assign bus.byte_ready_out           = ready_q;
    assign bus.obstaculos_wr_enable_out = wr_en_q;
    assign bus.obstaculos_wr_addr_out   = wr_addr_q;
    assign bus.obstaculos_wr_data_out   = wr_data_q;
    assign busy_out                     = busy_q;
    assign done_out                     = done_q;
    assign error_out                    = error_q;

`ifdef OBSTACULOS_MAP_COUNT_EN
    logic [CntW-1:0] cnt_q, cnt_d;

    // Count includes the strobe being registered this edge, so it tracks the write port exactly.
    always_comb begin
        cnt_d = cnt_q + {{ADDR_WIDTH{1'b0}}, (wr_en_d && wr_data_d)};
        if (starting) begin
            cnt_d = '0;
        end
    end

    // Obstacle count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign obst_count_out = cnt_q;
`endif

endmodule

// File: tb/tb_obstaculos_map_loader.sv
// Self-checking bench for obstaculos_map_loader (ADDR_WIDTH=4, MAP_CELLS=12 so a load ends
// mid-byte). A queue-based model predicts every output each cycle; directed scenarios add
// hand-computed expectations, then a randomized phase runs against the model.
module tb_obstaculos_map_loader;

    localparam int unsigned AW = 4;
    localparam int unsigned MC = 12;

    logic clk = 1'b0;
    logic rst, start_clear, start_load, abort_s;
    logic busy_out, done_out, error_out;
`ifdef OBSTACULOS_MAP_COUNT_EN
    logic [AW:0] obst_count;
`endif

    obstaculos_map_loader_if #(.ADDR_WIDTH(AW)) bus ();

    obstaculos_map_loader #(
        .ADDR_WIDTH(AW),
        .MAP_CELLS (MC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start_clear_in(start_clear),
        .start_load_in (start_load),
        .abort_in      (abort_s),
        .bus           (bus),
        .busy_out      (busy_out),
        .done_out      (done_out),
        .error_out     (error_out)
`ifdef OBSTACULOS_MAP_COUNT_EN
        ,
        .obst_count_out(obst_count)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;

    // Model: operation in progress, next address, bits of the current byte still to write.
    bit m_busy = 1'b0;
    bit m_clear = 1'b0;
    bit m_done = 1'b0;
    int m_next = 0;
    int m_cnt = 0;
    bit m_bits[$];
    // Expected outputs for the coming cycle.
    bit e_busy, e_done, e_err, e_ready, e_en, e_data;
    int e_addr, e_cnt;

    // Observation of the DUT for directed checks.
    logic tb_mem[16];
    int n_strobes, n_hs, n_err_seen, first_addr, done_rise, start_cyc;
    int ncyc_g = 0;
    bit done_prev = 1'b0;
    byte unsigned stream_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, ncyc_g);
    endtask

    // Advance the model by one clock edge with the inputs sampled at that edge.
    task automatic model_step(input bit r, input bit c, input bit l, input bit a, input bit v,
                              input logic [7:0] d);
        bit was_busy;
        was_busy = m_busy;
        e_err = 1'b0;
        if (r) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_next = 0;
            m_cnt  = 0;
            m_bits.delete();
        end else begin
            e_err = was_busy && (c || l);
            if (!was_busy) begin
                if (c || l) begin
                    m_busy  = 1'b1;
                    m_clear = c;
                    m_done  = 1'b0;
                    m_next  = 0;
                    m_cnt   = 0;
                    m_bits.delete();
                end
            end else if (a) begin
                m_busy = 1'b0;
                m_bits.delete();
            end else if (m_clear || m_bits.size() > 0) begin
                // The write shown this cycle retires.
                if (!m_clear) void'(m_bits.pop_front());
                if (m_next == int'(MC) - 1) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    m_bits.delete();
                end else begin
                    m_next++;
                end
            end else if (v) begin
                for (int i = 0; i < 8; i++) m_bits.push_back(d[i]);
            end
        end
        e_busy  = m_busy;
        e_done  = m_done;
        e_ready = m_busy && !m_clear && m_bits.size() == 0;
        e_en    = m_busy && (m_clear || m_bits.size() > 0);
        e_addr  = m_next;
        e_data  = e_en && !m_clear && m_bits[0];
        if (e_en && e_data) m_cnt++;
        e_cnt = m_cnt;
    endtask

    // One clock: compare at the falling edge, then drive inputs for the next rising edge.
    task automatic cycle(input bit r, input bit c, input bit l, input bit a, input bit v,
                         input logic [7:0] d);
        @(negedge clk);
        chk("busy", 32'(busy_out), 32'(e_busy));
        chk("done", 32'(done_out), 32'(e_done));
        chk("error", 32'(error_out), 32'(e_err));
        chk("byte_ready", 32'(bus.byte_ready_out), 32'(e_ready));
        chk("wr_enable", 32'(bus.obstaculos_wr_enable_out), 32'(e_en));
        if (e_en) begin
            chk("wr_addr", 32'(bus.obstaculos_wr_addr_out), e_addr);
            chk("wr_data", 32'(bus.obstaculos_wr_data_out), 32'(e_data));
        end
`ifdef OBSTACULOS_MAP_COUNT_EN
        chk("obst_count", 32'(obst_count), e_cnt);
`endif
        if (bus.obstaculos_wr_enable_out === 1'b1) begin
            if (first_addr < 0) first_addr = int'(bus.obstaculos_wr_addr_out);
            tb_mem[bus.obstaculos_wr_addr_out] = bus.obstaculos_wr_data_out;
            n_strobes++;
        end
        if (error_out === 1'b1) n_err_seen++;
        if (done_out === 1'b1 && !done_prev && done_rise < 0) done_rise = ncyc_g - start_cyc;
        done_prev = (done_out === 1'b1);

        rst = r;
        start_clear = c;
        start_load = l;
        abort_s = a;
        bus.byte_valid_in = v;
        bus.byte_data_in = d;
        if (v && bus.byte_ready_out === 1'b1) n_hs++;
        model_step(r, c, l, a, v, d);
        ncyc_g++;
    endtask

    function automatic logic [31:0] mem_bits();
        logic [31:0] res;
        res = '0;
        for (int i = 0; i < int'(MC); i++) res[i] = tb_mem[i];
        return res;
    endfunction

    // Start a clear or a load of stream_q at step 0, then run ncyc further cycles.
    // stall = valid-low cycles (counted while ready) after each accepted byte.
    task automatic run_op(input bit is_clear, input int stall, input int ncyc, input int sc_at,
                          input int ab_at);
        int idx, gap;
        bit v, rdy, c;
        logic [7:0] d;
        idx = 0;
        gap = 0;
        n_strobes = 0;
        n_hs = 0;
        n_err_seen = 0;
        first_addr = -1;
        done_rise = -1;
        start_cyc = ncyc_g;
        for (int i = 0; i < 16; i++) tb_mem[i] = 1'bx;
        for (int i = 0; i <= ncyc; i++) begin
            v = !is_clear && i > 0 && idx < stream_q.size() && gap == 0;
            d = v ? stream_q[idx] : 8'h00;
            rdy = e_ready;
            c = (is_clear && i == 0) || i == sc_at;
            cycle(1'b0, c, !is_clear && i == 0, i == ab_at, v, d);
            if (v && rdy) begin
                idx++;
                gap = stall;
            end else if (rdy && gap > 0) begin
                gap--;
            end
        end
    endtask

    initial begin
        bit rv, rr, hold, r, c, l, a;
        logic [7:0] rd;
        rst = 1'b1;
        start_clear = 1'b0;
        start_load = 1'b0;
        abort_s = 1'b0;
        bus.byte_valid_in = 1'b0;
        bus.byte_data_in = 8'h00;
        model_step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("reset_outputs", {27'd0, busy_out, done_out, error_out, bus.byte_ready_out,
                              bus.obstaculos_wr_enable_out}, 32'd0);

        // Clear: 12 strobes of 0, done one cycle after the last.
        run_op(1'b1, 0, 16, -1, -1);
        chk("clear_strobes", n_strobes, MC);
        chk("clear_mem", mem_bits(), 32'h0);
        chk("clear_done_latency", done_rise, 13);
        chk("clear_busy_after", 32'(busy_out), 32'd0);

        // Load 0xA5, 0x0F back to back.
        stream_q = {8'hA5, 8'h0F};
        run_op(1'b0, 0, 20, -1, -1);
        chk("load_mem", mem_bits(), 32'hFA5);
        chk("load_strobes", n_strobes, MC);
        chk("load_done_latency", done_rise, 15);
        chk("load_handshakes", n_hs, 2);
`ifdef OBSTACULOS_MAP_COUNT_EN
        chk("load_count", 32'(obst_count), 32'd8);
`endif

        // Full map ends mid-byte; a third byte must not be taken.
        stream_q = {8'hFF, 8'hFF, 8'hFF};
        run_op(1'b0, 0, 25, -1, -1);
        chk("full_mem", mem_bits(), 32'hFFF);
        chk("full_strobes", n_strobes, MC);
        chk("full_handshakes", n_hs, 2);
        chk("full_ready_after", 32'(bus.byte_ready_out), 32'd0);
        chk("full_done", 32'(done_out), 32'd1);

        // Valid stalled 5 ready cycles between bytes.
        stream_q = {8'h3C, 8'h81};
        run_op(1'b0, 5, 30, -1, -1);
        chk("stall_mem", mem_bits(), 32'h13C);
        chk("stall_strobes", n_strobes, MC);
        chk("stall_done_latency", done_rise, 20);

        // start_clear while writing addr 5 of a load.
        stream_q = {8'hF0, 8'h0F};
        run_op(1'b0, 0, 20, 7, -1);
        chk("busy_start_errors", n_err_seen, 1);
        chk("busy_start_mem", mem_bits(), 32'hFF0);
        chk("busy_start_done_latency", done_rise, 15);

        // Abort a clear while it writes addr 3.
        run_op(1'b1, 0, 5, -1, 4);
        chk("abort_strobes", n_strobes, 4);
        chk("abort_wr_enable", 32'(bus.obstaculos_wr_enable_out), 32'd0);
        chk("abort_busy", 32'(busy_out), 32'd0);
        chk("abort_done", 32'(done_out), 32'd0);

        // Load after abort restarts at addr 0.
        stream_q = {8'h55, 8'hAA};
        run_op(1'b0, 0, 20, -1, -1);
        chk("reload_first_addr", first_addr, 0);
        chk("reload_mem", mem_bits(), 32'hA55);
        chk("reload_done_latency", done_rise, 15);

        // Randomized traffic; data held while valid is high and ready low.
        rv = 1'b0;
        rr = 1'b0;
        rd = 8'h00;
        for (int i = 0; i < 4000; i++) begin
            hold = rv && !rr;
            r = ($urandom_range(299) == 0);
            c = ($urandom_range(59) == 0);
            l = ($urandom_range(29) == 0);
            a = ($urandom_range(149) == 0);
            if (!hold) begin
                rv = ($urandom_range(9) < 7);
                rd = 8'($urandom);
            end
            rr = e_ready;
            cycle(r, c, l, a, rv, rd);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
